// File: rtl/seq_detect_if.sv
// Serial pattern detector bus: data bit and pattern in, match flag out.
interface seq_detect_if #(
  parameter int N = 3
);
  logic         a;
  logic [N-1:0] seq;
  logic         valid;

  modport master (output a, output seq, input valid);
  modport slave  (input a, input seq, output valid);
endinterface

// File: rtl/seq_detect.sv
// Serial pattern detector: shifts one bit per clock into an N-bit window and
// flags whenever the window equals the programmable pattern (overlaps allowed).
module seq_detect #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  seq_detect_if.slave  bus
);
  localparam int FW = $clog2(N + 1);

  logic [N-1:0]  hist_q;
  logic [N-1:0]  hist_d;
  logic [FW-1:0] fill_q;
  logic [FW-1:0] fill_d;

  // Next-state: shift form works for N=1 as well; fill saturates at N.
  always_comb begin
    hist_d = (hist_q << 1'b1) | N'(bus.a);
    if (fill_q == FW'(N)) begin
      fill_d = fill_q;
    end else begin
      fill_d = fill_q + FW'(1);
    end
  end

  // History and fill state; reset discards all samples and ignores a.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  // Combinational against seq so a pattern change applies in the same cycle;
  // fill gating stops the zero-filled reset window matching an all-zero seq.
  assign bus.valid = (fill_q == FW'(N)) && (hist_q == bus.seq);

endmodule

// File: tb/tb_seq_detect.sv
// Directed bench for seq_detect: N=3 and N=1 instances on a shared clock.
module tb_seq_detect;
  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  seq_detect_if #(.N(3)) bus3 ();
  seq_detect_if #(.N(1)) bus1 ();

  seq_detect #(.N(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));
  seq_detect #(.N(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic a3_v, input logic a1_v);
    bus3.a = a3_v;
    bus1.a = a1_v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    bus3.seq = 3'b000;
    bus1.seq = 1'b0;
    bus3.a = 1'b1;
    bus1.a = 1'b1;
    reset_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (bus3.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_n3: valid=%b expected 0", bus3.valid);
    end
    checks++;
    if (bus1.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_n1: valid=%b expected 0", bus1.valid);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_pattern_011();
    logic [7:0] bits;
    logic [7:0] exp;
    bits = 8'h6B;
    exp  = 8'h40;
    bus3.seq = 3'b011;
    for (int i = 0; i < 8; i++) begin
      step(bits[i], 1'b0);
      checks++;
      if (bus3.valid !== exp[i]) begin
        errors++;
        $display("FAIL pat011 bit%0d: valid=%b expected %b", i + 1, bus3.valid, exp[i]);
      end
    end
  endtask

  task automatic test_overlap_111();
    logic [7:0] bits;
    logic [7:0] exp;
    bits = 8'hFB;
    exp  = 8'hE0;
    pulse_reset();
    bus3.seq = 3'b111;
    for (int i = 0; i < 8; i++) begin
      step(bits[i], 1'b0);
      checks++;
      if (bus3.valid !== exp[i]) begin
        errors++;
        $display("FAIL overlap111 bit%0d: valid=%b expected %b", i + 1, bus3.valid, exp[i]);
      end
    end
  endtask

  task automatic test_all_zero();
    logic [4:0] exp;
    exp = 5'b11100;
    pulse_reset();
    bus3.seq = 3'b000;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (bus3.valid !== exp[i]) begin
        errors++;
        $display("FAIL allzero edge%0d: valid=%b expected %b", i + 1, bus3.valid, exp[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    pulse_reset();
    bus3.seq = 3'b111;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (bus3.valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset pre%0d: valid=%b expected 0", i + 1, bus3.valid);
      end
    end
    bus3.a = 1'b1;
    pulse_reset();
    checks++;
    if (bus3.valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset rst: valid=%b expected 0", bus3.valid);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (bus3.valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset post%0d: valid=%b expected 0", i + 1, bus3.valid);
      end
    end
    step(1'b1, 1'b0);
    checks++;
    if (bus3.valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset third: valid=%b expected 1", bus3.valid);
    end
  endtask

  task automatic test_seq_change();
    logic [2:0] bits;
    bits = 3'b101;
    pulse_reset();
    bus3.seq = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      step(bits[i], 1'b0);
    end
    checks++;
    if (bus3.valid !== 1'b0) begin
      errors++;
      $display("FAIL seqchg before: valid=%b expected 0", bus3.valid);
    end
    bus3.seq = 3'b101;
    #1;
    checks++;
    if (bus3.valid !== 1'b1) begin
      errors++;
      $display("FAIL seqchg after: valid=%b expected 1", bus3.valid);
    end
  endtask

  task automatic test_n1();
    logic [3:0] bits;
    logic [3:0] exp;
    bits = 4'b0110;
    exp  = 4'b0110;
    pulse_reset();
    bus1.seq = 1'b1;
    checks++;
    if (bus1.valid !== 1'b0) begin
      errors++;
      $display("FAIL n1 reset: valid=%b expected 0", bus1.valid);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, bits[i]);
      checks++;
      if (bus1.valid !== exp[i]) begin
        errors++;
        $display("FAIL n1 bit%0d: valid=%b expected %b", i + 1, bus1.valid, exp[i]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset_n  = 1'b0;
    bus3.a   = 1'b0;
    bus1.a   = 1'b0;
    bus3.seq = 3'b000;
    bus1.seq = 1'b0;
    @(negedge clk);
    test_reset();
    test_pattern_011();
    test_overlap_111();
    test_all_zero();
    test_mid_reset();
    test_seq_change();
    test_n1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
